io_uart_in: RTL and testbench

IO_UART_IN -- requirements
Module: io_uart_in

---
 rtl/io_uart_in.sv | 230 +++++++++++++++++++++++
 tb/tb_io_uart_in.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_in.sv
// io_uart_in: 8N1 UART receiver with an 8-deep RX FIFO.
// Exposes a data/status register pair on the daisy-chained DMA IO bus.
// Read data is registered; non-hit cycles forward the upstream read data.
module io_uart_in #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [13:0] ADR_DATA     = 14'h3F10,
  parameter logic [13:0] ADR_STAT     = 14'h3F11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        dma_io_we,
  input  logic [13:0] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [13:0] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  output logic        rx_irq
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchronizer and edge history
  logic rx_s1, rx_s2, rx_prev;

  // Receiver state
  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          push, ferr_set;

  // FIFO
  logic [7:0] mem [8];
  logic [2:0] wr_ptr, rd_ptr;
  logic [3:0] count;
  logic       full, nonempty, pop, do_push, ovr_set;

  // Control/status
  logic ovr, ferr, ie;
  logic stat_we, ovr_clr, ferr_clr;

  // Read path
  logic        rd_hit, rd_hit_d;
  logic [31:0] rd_data_q, own_d;

  logic unused_wdata;
  assign unused_wdata = ^{dma_io_wdata[31:9], dma_io_wdata[7:4], dma_io_wdata[1:0]};

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
    end
  end

  // Receiver next-state: bit timing, sampling, push and framing-error events
  always_comb begin
    state_d   = state;
    timer_d   = timer;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_prev && !rx_s2) begin
          timer_d = HALF_LOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (timer == '0) begin
          if (!rx_s2) begin
            timer_d   = BIT_LOAD;
            bit_idx_d = '0;
            state_d   = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      S_DATA: begin
        if (timer == '0) begin
          shreg_d = {rx_s2, shreg[7:1]};
          timer_d = BIT_LOAD;
          if (bit_idx == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      S_STOP: begin
        if (timer == '0) begin
          if (rx_s2) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s2) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign full     = (count == 4'd8);
  assign nonempty = (count != 4'd0);
  assign pop      = dma_io_radr_en && (dma_io_radr == ADR_DATA) && nonempty;
  // A pop in the same cycle frees a slot, so a push at full still lands
  assign do_push  = push && (!full || pop);
  assign ovr_set  = push && full && !pop;

  assign stat_we  = dma_io_we && (dma_io_wadr == ADR_STAT);
  assign ovr_clr  = stat_we && dma_io_wdata[2];
  assign ferr_clr = stat_we && dma_io_wdata[3];

  // FIFO storage, not reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= shreg;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)     rd_ptr <= rd_ptr + 3'd1;
      case ({do_push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags (set beats clear) and interrupt enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
      ie   <= 1'b0;
    end else begin
      if (ovr_set)       ovr <= 1'b1;
      else if (ovr_clr)  ovr <= 1'b0;
      if (ferr_set)      ferr <= 1'b1;
      else if (ferr_clr) ferr <= 1'b0;
      if (stat_we)       ie <= dma_io_wdata[8];
    end
  end

  // Own read data selection for the addressed register
  always_comb begin
    own_d    = '0;
    rd_hit_d = dma_io_radr_en && ((dma_io_radr == ADR_DATA) || (dma_io_radr == ADR_STAT));
    if (dma_io_radr == ADR_DATA) begin
      if (nonempty) begin
        own_d = {23'd0, 1'b1, mem[rd_ptr]};
      end
    end else begin
      own_d = {23'd0, ie, count, ferr, ovr, full, nonempty};
    end
  end

  // Registered read hit/data and interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_hit    <= 1'b0;
      rd_data_q <= '0;
      rx_irq    <= 1'b0;
    end else begin
      rd_hit <= rd_hit_d;
      if (rd_hit_d) rd_data_q <= own_d;
      rx_irq <= ie && nonempty;
    end
  end

  assign dma_io_rdata = rd_hit ? rd_data_q : dma_io_rdata_in;

endmodule

// File: tb/tb_io_uart_in.sv
// tb_io_uart_in: directed scenarios plus randomized traffic for io_uart_in,
// checked against a queue-based model of the receive FIFO and flags.
module tb_io_uart_in;

  localparam int          CPB      = 16;
  localparam logic [13:0] A_DATA   = 14'h3F10;
  localparam logic [13:0] A_STAT   = 14'h3F11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        dma_io_we = 1'b0;
  logic [13:0] dma_io_wadr = '0;
  logic [31:0] dma_io_wdata = '0;
  logic [13:0] dma_io_radr = '0;
  logic        dma_io_radr_en = 1'b0;
  logic [31:0] dma_io_rdata_in = '0;
  logic [31:0] dma_io_rdata;
  logic        rx_irq;

  io_uart_in #(
    .CLKS_PER_BIT(CPB),
    .ADR_DATA    (A_DATA),
    .ADR_STAT    (A_STAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx             (rx),
    .dma_io_we      (dma_io_we),
    .dma_io_wadr    (dma_io_wadr),
    .dma_io_wdata   (dma_io_wdata),
    .dma_io_radr    (dma_io_radr),
    .dma_io_radr_en (dma_io_radr_en),
    .dma_io_rdata_in(dma_io_rdata_in),
    .dma_io_rdata   (dma_io_rdata),
    .rx_irq         (rx_irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: received bytes and register flags
  logic [7:0] q[$];
  logic       m_ovr = 1'b0, m_ferr = 1'b0, m_ie = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp();
    logic [3:0] c;
    c = 4'(q.size());
    return {23'd0, m_ie, c, m_ferr, m_ovr, (c == 4'd8), (c != 4'd0)};
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (q.size() == 8) m_ovr = 1'b1;
    else q.push_back(b);
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_ie   = 1'b0;
  endfunction

  task automatic hold_rx(input logic v, input int cycles);
    rx = v;
    repeat (cycles) @(posedge clk);
  endtask

  // One 8N1 frame; a bad stop keeps rx low for stop_bits bit times
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int stop_bits);
    hold_rx(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_rx(b[i], CPB);
    if (stop_ok) hold_rx(1'b1, CPB);
    else hold_rx(1'b0, CPB * stop_bits);
    hold_rx(1'b1, 6);
  endtask

  task automatic io_write(input logic [13:0] adr, input logic [31:0] d);
    @(posedge clk); #1;
    dma_io_we = 1'b1; dma_io_wadr = adr; dma_io_wdata = d;
    @(posedge clk); #1;
    dma_io_we = 1'b0;
  endtask

  // Strobe one read, return the presented word, then confirm forwarding resumes
  task automatic io_read(input logic [13:0] adr, output logic [31:0] d);
    @(posedge clk); #1;
    dma_io_radr = adr; dma_io_radr_en = 1'b1; dma_io_rdata_in = $urandom;
    @(posedge clk); #1;
    dma_io_radr_en = 1'b0;
    d = dma_io_rdata;
    @(posedge clk); #1;
    dma_io_rdata_in = $urandom;
    #1;
    check("passthru", dma_io_rdata, dma_io_rdata_in);
  endtask

  task automatic check_stat(input string tag);
    logic [31:0] got;
    io_read(A_STAT, got);
    check(tag, got, stat_exp());
  endtask

  task automatic check_data(input string tag);
    logic [31:0] got, exp;
    exp = '0;
    if (q.size() > 0) exp = {23'd0, 1'b1, q.pop_front()};
    io_read(A_DATA, got);
    check(tag, got, exp);
  endtask

  task automatic stat_write(input logic [31:0] d);
    io_write(A_STAT, d);
    if (d[2]) m_ovr = 1'b0;
    if (d[3]) m_ferr = 1'b0;
    m_ie = d[8];
  endtask

  initial begin
    logic [7:0]  b;
    logic [13:0] adr;
    logic [31:0] wd;
    int          r;

    // Reset state
    dma_io_rdata_in = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    check("rst_irq", {31'd0, rx_irq}, 32'd0);
    check("rst_fwd", dma_io_rdata, 32'h1234_5678);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    check_stat("rst_stat");

    // Single byte
    send_frame(8'hA5, 1'b1, 1);
    model_push(8'hA5);
    check_stat("a5_stat");
    check("a5_stat_const", stat_exp(), 32'h011);
    check_data("a5_data");
    check_stat("a5_stat_empty");

    // Overflow: nine bytes into eight slots
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1, 1);
      model_push(8'(i));
    end
    check_stat("ovr_stat");
    for (int i = 0; i < 9; i++) check_data("ovr_drain");
    stat_write(32'h004);
    check_stat("ovr_clr");

    // Framing error with long break
    send_frame(8'h3C, 1'b0, 40);
    m_ferr = 1'b1;
    check_stat("ferr_stat");
    stat_write(32'h008);
    check_stat("ferr_clr");
    send_frame(8'h55, 1'b1, 1);
    model_push(8'h55);
    check_data("after_break");

    // Short glitch: no byte, no error, receiver still usable
    hold_rx(1'b0, 4);
    hold_rx(1'b1, 3 * CPB);
    check_stat("glitch_stat");
    send_frame(8'hC3, 1'b1, 1);
    model_push(8'hC3);
    check_data("after_glitch");

    // Interrupt
    stat_write(32'h100);
    check("irq_idle", {31'd0, rx_irq}, 32'd0);
    send_frame(8'h7E, 1'b1, 1);
    model_push(8'h7E);
    check("irq_rise", {31'd0, rx_irq}, 32'd1);
    check_data("irq_data");
    check("irq_fall", {31'd0, rx_irq}, 32'd0);

    // Non-matching address forwards upstream data
    @(posedge clk); #1;
    dma_io_radr = 14'h0123; dma_io_radr_en = 1'b1; dma_io_rdata_in = 32'hDEADBEEF;
    @(posedge clk); #1;
    check("miss_fwd", dma_io_rdata, 32'hDEADBEEF);
    dma_io_radr_en = 1'b0;

    // Reset during DATA with a byte pending and IE set
    send_frame(8'h11, 1'b1, 1);
    model_push(8'h11);
    check("pre_rst_irq", {31'd0, rx_irq}, 32'd1);
    hold_rx(1'b0, CPB);
    hold_rx(1'b1, 2 * CPB);
    #1;
    rst = 1'b1;
    dma_io_rdata_in = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_irq", {31'd0, rx_irq}, 32'd0);
    check("midrst_fwd", dma_io_rdata, 32'hCAFE_F00D);
    rst = 1'b0;
    model_reset();
    hold_rx(1'b1, 12 * CPB);
    check_stat("midrst_stat");
    send_frame(8'h5A, 1'b1, 1);
    model_push(8'h5A);
    check_data("midrst_resume");

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      b = 8'($urandom);
      if (r < 7) begin
        send_frame(b, 1'b1, 1);
        model_push(b);
      end else if (r == 7) begin
        send_frame(b, 1'b0, 1);
        m_ferr = 1'b1;
      end else if (r == 8) begin
        wd = $urandom;
        stat_write(wd);
      end else begin
        adr = 14'($urandom);
        if (adr == A_STAT) adr = A_DATA;
        io_write(adr, $urandom);
      end
      r = $urandom_range(0, 3);
      for (int k = 0; k < r; k++) begin
        if ($urandom_range(0, 1) == 1) check_data("rnd_data");
        else check_stat("rnd_stat");
      end
      repeat (2) @(posedge clk);
      #1;
      check("rnd_irq", {31'd0, rx_irq}, {31'd0, (m_ie && q.size() != 0)});
    end
    check_stat("final_stat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
